// File: rtl/clk_n_monitor_if.sv
// Bundle between the divided-clock source side and the clk_N monitor.
// The master drives the slow clock and enable; the monitor (slave) returns pulses and measurements.
interface clk_n_monitor_if #(
    parameter int unsigned CNT_W = 32
);
    logic             clk_N_in;
    logic             en;
    logic             rise_pulse;
    logic             fall_pulse;
    logic [CNT_W-1:0] half_period;
    logic             period_valid;
    logic             stalled;
    logic [15:0]      edge_count;

    modport master (
        output clk_N_in, en,
        input  rise_pulse, fall_pulse, half_period, period_valid, stalled, edge_count
    );

    modport slave (
        input  clk_N_in, en,
        output rise_pulse, fall_pulse, half_period, period_valid, stalled, edge_count
    );
endinterface

// File: rtl/clk_n_monitor.sv
// Brings the divided clock clk_N into the clk domain as rise/fall enables,
// measures its half-period in clk cycles and flags an input that stops toggling.
module clk_n_monitor #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned TIMEOUT     = 100_000_000
) (
    input logic           clk,
    input logic           rst_n,
    clk_n_monitor_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ARMED, LOCKED} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev;
    logic [CNT_W-1:0]       cnt;
    logic                   sync_out;
    logic                   rise;
    logic                   fall;
    logic                   edge_det;

    always_comb begin
        sync_out = sync_q[SYNC_STAGES-1];
        rise     = sync_out & ~prev;
        fall     = ~sync_out & prev;
        edge_det = rise | fall;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q           <= '0;
            prev             <= 1'b0;
            cnt              <= '0;
            state            <= IDLE;
            bus.rise_pulse   <= 1'b0;
            bus.fall_pulse   <= 1'b0;
            bus.half_period  <= '0;
            bus.period_valid <= 1'b0;
            bus.stalled      <= 1'b0;
            bus.edge_count   <= '0;
        end else begin
            // Synchronizer and prev keep running while disabled so re-enable sees no stale edge.
            sync_q         <= {sync_q[SYNC_STAGES-2:0], bus.clk_N_in};
            prev           <= sync_out;
            bus.rise_pulse <= bus.en & rise;
            bus.fall_pulse <= bus.en & fall;

            if (!bus.en) begin
                cnt              <= '0;
                state            <= IDLE;
                bus.stalled      <= 1'b0;
                bus.period_valid <= 1'b0;
            end else begin
                if (rise) begin
                    bus.edge_count <= bus.edge_count + 16'd1;
                end

                if (edge_det) begin
                    // An edge takes priority over a timeout landing on the same cycle.
                    cnt         <= '0;
                    bus.stalled <= 1'b0;
                    if (state == IDLE) begin
                        state            <= ARMED;
                        bus.period_valid <= 1'b0;
                    end else begin
                        bus.half_period  <= cnt + 1'b1;
                        state            <= LOCKED;
                        bus.period_valid <= 1'b1;
                    end
                end else if (cnt == CNT_MAX) begin
                    if (state != IDLE) begin
                        bus.stalled      <= 1'b1;
                        state            <= IDLE;
                        bus.period_valid <= 1'b0;
                    end
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: doc/clk_n_monitor.md
Name: clk_n_monitor

Overview:
- Receiving end of the divided slow clock (`clk_N`) that feeds the display/CPU single-step logic.
- Synchronizes `clk_N` into the fast `clk` domain and emits one-cycle rise/fall enable pulses, so downstream logic runs on `clk` and never clocks on `clk_N`.
- Also measures the half-period of `clk_N` in `clk` cycles and flags a stalled (non-toggling) input.

Parameters:
- SYNC_STAGES, 2: synchronizer flops on `clk_N_in`. Legal values 2..4.
- CNT_W, 32: width of the half-period counter and measurement.
- TIMEOUT, 100_000_000: `clk` cycles without any edge before `stalled` asserts. Must satisfy 2 ≤ TIMEOUT < 2^CNT_W.

Ports:
- clk  in  1  system clock, all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clk_N_in  in  1  divided clock. Asynchronous to this block's sampling.
- en  in  1  monitor enable.
- rise_pulse  out  1  one-cycle pulse per synchronized rising edge.
- fall_pulse  out  1  one-cycle pulse per synchronized falling edge.
- half_period  out  CNT_W  last measured edge-to-edge spacing, in `clk` cycles.
- period_valid  out  1  `half_period` holds a measurement from consecutive edges.
- stalled  out  1  no edge seen for TIMEOUT cycles.
- edge_count  out  16  count of rising edges, wraps.

Behaviour:
- **Reset** (`rst_n`=0, asynchronous):
  - Sync chain, previous-sample flop, counter and all outputs go to 0.
  - State goes to IDLE.
  - Release is synchronous to the next `clk` edge.
- **Synchronizer and edge detect:**
  - SYNC_STAGES-deep flop chain, then a `prev` flop.
  - rise = sync_out & ~prev; fall = ~sync_out & prev.
  - Pulses are registered outputs.
  - Latency: `clk_N_in` first sampled high at `clk` edge k gives `rise_pulse`=1 in the cycle after edge k+SYNC_STAGES, for exactly one cycle.
  - The chain and `prev` run regardless of `en`, so re-enabling never yields a spurious edge.
- **Enable:**
  - `en`=0 forces `rise_pulse`=`fall_pulse`=0, cnt=0, state IDLE, `stalled`=0, `period_valid`=0.
  - `en`=0 holds `half_period` and `edge_count`.
- **Counter cnt:**
  - While `en`: increments each cycle with no detected edge, saturating at TIMEOUT-1.
  - On a detected edge (rise or fall), cnt is cleared to 0.
- **State machine:**
  - IDLE, any edge: go to ARMED, cnt=0. No measurement.
  - ARMED, edge: `half_period` ← cnt+1, go to LOCKED.
  - LOCKED, edge: `half_period` ← cnt+1, stay in LOCKED.
  - ARMED or LOCKED, cnt == TIMEOUT-1 with no edge: `stalled` ← 1, go to IDLE. `half_period` holds.
  - `stalled` clears on the next detected edge; the state goes to ARMED on that same cycle.
  - IDLE with `stalled` high does not re-time-out.
- **Outputs derived from state:**
  - `period_valid` = (state == LOCKED), registered.
  - `edge_count` increments by 1 on each `rise_pulse` and wraps 0xFFFF→0.
- **Boundary cases:**
  - Edge on the same cycle cnt reaches TIMEOUT-1: the edge wins. `stalled` stays 0 and `half_period` = TIMEOUT.
  - Input toggling faster than once per `clk`: edges may be missed. Unsupported, no error flag.
  - Width: cnt+1 ≤ TIMEOUT < 2^CNT_W, so no overflow.
- **Reset mid-measurement:**
  - All state is lost; the next edge is treated as first (ARMED).
  - `half_period` reads 0 until the second edge after reset.
- **Divider compatibility:** a divider with parameter N toggles every N+1 `clk` cycles, so in LOCKED `half_period` must equal N+1.

Test Plan:
1. Reset/latency (SYNC_STAGES=2): hold `rst_n`=0, check all outputs 0. Release, `en`=1, drive `clk_N_in` high before edge k. Expect `rise_pulse`=1 only in the cycle after edge k+2, `edge_count`=1, `half_period`=0, `period_valid`=0.
2. Measurement: drive `clk_N_in` as a divider with N=3 (toggle every 4 cycles). After the second edge, expect `period_valid`=1 and `half_period`=4. Rise and fall pulses alternate 4 cycles apart; after 10 rises, `edge_count`=10.
3. Stall (TIMEOUT=20): lock on period 4, then freeze the input. Expect `stalled`=1 exactly 20 cycles after the last edge pulse, `period_valid`=0, `half_period` still 4. On the next toggle, `stalled`=0 and state ARMED. After a further 4-cycle edge, LOCKED again with `half_period`=4.
4. Edge/timeout collision (TIMEOUT=20): place an edge exactly 20 cycles after the previous one. Expect `stalled` stays 0, `half_period`=20, `period_valid` stays 1.
5. Enable gating: with the clock locked, drop `en` for 9 cycles across an input edge. Expect no pulses and outputs held. Re-raise `en`: expect no spurious pulse, IDLE→ARMED on the next edge, `period_valid` back to 1 after the second edge.
6. Wrap and async reset: preload 65535 rises, then one more rise; expect `edge_count`=0. Assert `rst_n` low mid-half-period, not aligned to `clk`; expect all outputs 0 immediately, before the next `clk` edge.
